// File: rtl/conv_fmap_streamer.sv
// Buffers one multi-channel feature map, then replays it NUMBER_OF_PASSES times as a valid/ready stream.
// Optional 1-pixel zero border per channel when CONV_FMAP_ZERO_PAD_EN is defined.
module conv_fmap_streamer #(
  parameter int DATA_WIDTH        = 32,
  parameter int IMAGE_WIDTH       = 5,
  parameter int NUMBER_OF_CHANNEL = 8,
  parameter int NUMBER_OF_PASSES  = 8,
  localparam int CHW = (NUMBER_OF_CHANNEL > 1) ? $clog2(NUMBER_OF_CHANNEL) : 1,
  localparam int PSW = (NUMBER_OF_PASSES > 1) ? $clog2(NUMBER_OF_PASSES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CHW-1:0]        o_channel,
  output logic [PSW-1:0]        o_pass,
  output logic                  o_last,
  output logic                  o_done,
  output logic                  o_overrun
);

  localparam int PIX   = IMAGE_WIDTH * IMAGE_WIDTH;
  localparam int DEPTH = NUMBER_OF_CHANNEL * PIX;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef CONV_FMAP_ZERO_PAD_EN
  localparam int SIDE  = IMAGE_WIDTH + 2;
`else
  localparam int SIDE  = IMAGE_WIDTH;
`endif
  localparam int RW    = (SIDE > 1) ? $clog2(SIDE) : 1;

  localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [RW-1:0]  LAST_SIDE = RW'(SIDE - 1);
  localparam logic [CHW-1:0] LAST_CHAN = CHW'(NUMBER_OF_CHANNEL - 1);
  localparam logic [PSW-1:0] LAST_PASS = PSW'(NUMBER_OF_PASSES - 1);

  typedef enum logic {FILL, SEND} state_t;
  state_t r_state, w_nextState;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdData;
  logic [AW-1:0]         r_wrAddr, r_rdAddr;
  logic [RW-1:0]         r_row, r_col;
  logic [CHW-1:0]        r_chan, r_s1Chan;
  logic [PSW-1:0]        r_passCnt, r_s1Pass;
  logic                  r_issueDone, r_s1Valid, r_s1Last;
`ifdef CONV_FMAP_ZERO_PAD_EN
  logic                  r_s1Zero;
`endif

  logic w_wrEn, w_lastWrite, w_outLoad, w_xfer, w_finalXfer, w_s1Free, w_issue, w_rdEn;
  logic w_colEnd, w_rowEnd, w_chanEnd, w_passEnd, w_issueLast, w_border;
  logic [DATA_WIDTH-1:0] w_s1Word;

  assign o_ready     = (r_state == FILL);
  assign w_wrEn      = i_valid && o_ready;
  assign w_lastWrite = w_wrEn && (r_wrAddr == LAST_ADDR);
  assign w_outLoad   = !o_valid || i_ready;
  assign w_xfer      = o_valid && i_ready;
  assign w_finalXfer = w_xfer && o_last && (o_pass == LAST_PASS);
  assign w_s1Free    = !r_s1Valid || w_outLoad;
  assign w_colEnd    = (r_col == LAST_SIDE);
  assign w_rowEnd    = (r_row == LAST_SIDE);
  assign w_chanEnd   = (r_chan == LAST_CHAN);
  assign w_passEnd   = (r_passCnt == LAST_PASS);
  assign w_issueLast = w_colEnd && w_rowEnd && w_chanEnd;

  // The first read is launched alongside the final write to hide one cycle of read latency.
  assign w_issue = w_s1Free && (((r_state == SEND) && !r_issueDone) || ((DEPTH > 1) && w_lastWrite));

`ifdef CONV_FMAP_ZERO_PAD_EN
  assign w_border = (r_row == '0) || w_rowEnd || (r_col == '0) || w_colEnd;
  assign w_s1Word = r_s1Zero ? '0 : r_rdData;
`else
  assign w_border = 1'b0;
  assign w_s1Word = r_rdData;
`endif
  assign w_rdEn = w_issue && !w_border;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FILL:    if (w_lastWrite) w_nextState = SEND;
      SEND:    if (w_finalXfer) w_nextState = FILL;
      default: w_nextState = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_wrAddr <= '0;
    else if (w_wrEn) r_wrAddr <= (r_wrAddr == LAST_ADDR) ? '0 : r_wrAddr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_wrEn) r_mem[r_wrAddr] <= i_data;
    if (w_rdEn) r_rdData <= r_mem[r_rdAddr];
  end

  // Issue counters walk pass/channel/row/column; the read address only moves on stored pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdAddr    <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_chan      <= '0;
      r_passCnt   <= '0;
      r_issueDone <= 1'b0;
    end else begin
      if (w_issue) begin
        if (!w_border) r_rdAddr <= (r_rdAddr == LAST_ADDR) ? '0 : r_rdAddr + 1'b1;
        if (!w_colEnd) begin
          r_col <= r_col + 1'b1;
        end else begin
          r_col <= '0;
          if (!w_rowEnd) begin
            r_row <= r_row + 1'b1;
          end else begin
            r_row <= '0;
            if (!w_chanEnd) begin
              r_chan <= r_chan + 1'b1;
            end else begin
              r_chan <= '0;
              if (!w_passEnd) begin
                r_passCnt <= r_passCnt + 1'b1;
              end else begin
                r_passCnt   <= '0;
                r_issueDone <= 1'b1;
              end
            end
          end
        end
      end
      if (w_finalXfer) r_issueDone <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1Chan  <= '0;
      r_s1Pass  <= '0;
      r_s1Last  <= 1'b0;
`ifdef CONV_FMAP_ZERO_PAD_EN
      r_s1Zero  <= 1'b0;
`endif
    end else if (w_issue) begin
      r_s1Valid <= 1'b1;
      r_s1Chan  <= r_chan;
      r_s1Pass  <= r_passCnt;
      r_s1Last  <= w_issueLast;
`ifdef CONV_FMAP_ZERO_PAD_EN
      r_s1Zero  <= w_border;
`endif
    end else if (w_outLoad) begin
      r_s1Valid <= 1'b0;
    end
  end

  // Output register only reloads when empty or consumed, so everything holds during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_channel <= '0;
      o_pass    <= '0;
      o_last    <= 1'b0;
      o_done    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      if (w_outLoad) begin
        o_valid   <= r_s1Valid;
        o_data    <= r_s1Valid ? w_s1Word : '0;
        o_channel <= r_s1Valid ? r_s1Chan : '0;
        o_pass    <= r_s1Valid ? r_s1Pass : '0;
        o_last    <= r_s1Valid && r_s1Last;
      end
      o_done <= w_finalXfer;
      if (i_valid && !o_ready) o_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_fmap_streamer.sv
// Scoreboard bench for conv_fmap_streamer (W=3, C=2, P=3); expected words follow
// CONV_FMAP_ZERO_PAD_EN when defined.
module tb_conv_fmap_streamer;

  localparam int W    = 3;
  localparam int C    = 2;
  localparam int P    = 3;
  localparam int DW   = 32;
  localparam int PIX  = W * W;
`ifdef CONV_FMAP_ZERO_PAD_EN
  localparam int SIDE = W + 2;
  localparam int OFF  = 1;
`else
  localparam int SIDE = W;
  localparam int OFF  = 0;
`endif
  localparam int WORDS = P * C * SIDE * SIDE;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_ready = 1'b0;
  logic          o_ready, o_valid, o_last, o_done, o_overrun;
  logic [DW-1:0] o_data;
  logic [0:0]    o_channel;
  logic [1:0]    o_pass;

  typedef struct {
    logic [DW-1:0] data;
    int            chan;
    int            pass;
    logic          last;
  } exp_t;

  exp_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   xferCount = 0;
  int   doneCount = 0;

  conv_fmap_streamer #(
    .DATA_WIDTH(DW), .IMAGE_WIDTH(W), .NUMBER_OF_CHANNEL(C), .NUMBER_OF_PASSES(P)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
    .i_ready(i_ready), .o_valid(o_valid), .o_data(o_data), .o_channel(o_channel),
    .o_pass(o_pass), .o_last(o_last), .o_done(o_done), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"},   o_ready, 1);
    checkOutput({tag, "_valid"},   o_valid, 0);
    checkOutput({tag, "_data"},    o_data, 0);
    checkOutput({tag, "_channel"}, o_channel, 0);
    checkOutput({tag, "_pass"},    o_pass, 0);
    checkOutput({tag, "_last"},    o_last, 0);
    checkOutput({tag, "_done"},    o_done, 0);
    checkOutput({tag, "_overrun"}, o_overrun, 0);
  endtask

  // Queue the full replay sequence for a map holding base..base+C*PIX-1, then write it.
  task automatic applyStimulus(input int base);
    for (int p = 0; p < P; p++)
      for (int c = 0; c < C; c++)
        for (int r = 0; r < SIDE; r++)
          for (int col = 0; col < SIDE; col++) begin
            exp_t e;
            if (OFF == 1 && (r == 0 || r == SIDE - 1 || col == 0 || col == SIDE - 1))
              e.data = '0;
            else
              e.data = DW'(base + c * PIX + (r - OFF) * W + (col - OFF));
            e.chan = c;
            e.pass = p;
            e.last = (c == C - 1) && (r == SIDE - 1) && (col == SIDE - 1);
            expQ.push_back(e);
          end
    for (int i = 0; i < C * PIX; i++) begin
      i_valid = 1'b1;
      i_data  = DW'(base + i);
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
  endtask

  task automatic waitDone(input string name, input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_done && n < limit);
    checkOutput(name, o_done, 1);
  endtask

  task automatic waitXfers(input int target, input int limit);
    int n = 0;
    while (xferCount < target && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("xfer_wait", DW'(xferCount >= target), 1);
  endtask

  logic          pendDone = 1'b0;
  logic          prevStall = 1'b0;
  logic [DW-1:0] prevData;
  logic [0:0]    prevChan;
  logic [1:0]    prevPass;
  logic          prevLast;

  // Monitor: pops the scoreboard on every transfer and checks hold behaviour across stalls.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pendDone  = 1'b0;
      prevStall = 1'b0;
    end else begin
      if (pendDone) begin
        checkOutput("done_pulse", o_done, 1);
        checkOutput("valid_after_done", o_valid, 0);
        pendDone = 1'b0;
      end else begin
        checkOutput("done_idle", o_done, 0);
      end
      if (o_done) doneCount++;
      if (prevStall) begin
        checkOutput("stall_valid", o_valid, 1);
        checkOutput("stall_data", o_data, prevData);
        checkOutput("stall_channel", o_channel, prevChan);
        checkOutput("stall_pass", o_pass, prevPass);
        checkOutput("stall_last", o_last, prevLast);
      end
      if (o_valid && i_ready) begin
        xferCount++;
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_word: got 0x%0h, want no word", o_data);
        end else begin
          e = expQ.pop_front();
          checkOutput("data", o_data, e.data);
          checkOutput("channel", o_channel, DW'(e.chan));
          checkOutput("pass", o_pass, DW'(e.pass));
          checkOutput("last", o_last, e.last);
          if (e.last && e.pass == P - 1) pendDone = 1'b1;
        end
      end
      prevStall = o_valid && !i_ready;
      prevData  = o_data;
      prevChan  = o_channel;
      prevPass  = o_pass;
      prevLast  = o_last;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int cyc;
    int d0;
    int n;

    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-rate replay: latency, back-to-back words across channel/pass boundaries.
    i_ready = 1'b1;
    applyStimulus(1);
    checkOutput("ready_low_in_send", o_ready, 0);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!o_valid && lat < 10);
    checkOutput("first_valid_within_2", DW'(lat <= 2), 1);
    cyc = 0;
    do begin
      @(negedge clk);
      if (!o_done) cyc++;
    end while (!o_done && cyc < WORDS + 20);
    checkOutput("stream_cycles", DW'(cyc), DW'(WORDS));
    checkOutput("done_seen", o_done, 1);
    checkOutput("ready_in_done_cycle", o_ready, 1);

    // Fill starting in the done cycle, then drain with random backpressure.
    applyStimulus(101);
    d0 = doneCount;
    n = 0;
    while (doneCount == d0 && n < 3000) begin
      @(posedge clk);
      #1;
      i_ready = 1'($urandom_range(0, 1));
      n++;
    end
    checkOutput("random_ready_done", DW'(doneCount != d0), 1);
    i_ready = 1'b1;
    @(posedge clk);
    #1;

    // Writes during SEND are dropped and flag a sticky overrun.
    applyStimulus(301);
    waitXfers(xferCount + 10, 200);
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1;
      i_data  = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    checkOutput("overrun_set", o_overrun, 1);
    waitDone("overrun_run_done", 500);
    checkOutput("overrun_sticky", o_overrun, 1);
    checkOutput("ready_after_done", o_ready, 1);

    // Asynchronous reset mid-stream, then a fresh map.
    applyStimulus(401);
    waitXfers(xferCount + 7, 200);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1);
    waitDone("post_reset_done", 500);
    checkOutput("queue_empty", DW'(expQ.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
